nios_system_scene_status: RTL

NIOS_SYSTEM_SCENE_STATUS -- requirements
Module: nios_system_scene_status

---
 rtl/nios_system_pkg.sv | 26 ++
 rtl/nios_system_sync2.sv | 26 ++
 rtl/nios_system_scene_status.sv | 75 +++++++
 3 files changed

// File: rtl/nios_system_pkg.sv
// Shared constants for the nios_system PIO peripherals: register word
// addresses and small bus-decode helpers.
package nios_system_pkg;

  // Scene-status PIO register map
  typedef enum logic [1:0] {
    SCENE_ADDR_DATA     = 2'd0,
    SCENE_ADDR_RESERVED = 2'd1,
    SCENE_ADDR_IRQMASK  = 2'd2,
    SCENE_ADDR_EDGECAP  = 2'd3
  } scene_reg_e;

  // Generic Avalon PIO layout used by the other PIO blocks in the system
  localparam logic [1:0] PIO_ADDR_DATA      = 2'd0;
  localparam logic [1:0] PIO_ADDR_DIRECTION = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK   = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP   = 2'd3;

  localparam int AVALON_DATA_W = 32;

  // Active-low strobe qualified by chipselect
  function automatic logic bus_strobe(input logic cs, input logic strobe_n);
    return cs & ~strobe_n;
  endfunction

endpackage

// File: rtl/nios_system_sync2.sv
// Two-flop synchronizer for a bus of independent asynchronous status bits.
module nios_system_sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/nios_system_scene_status.sv
// Avalon-MM status PIO for scene hardware: synchronized input, per-bit
// rising-edge capture with write-1-to-clear, and a masked level interrupt.
module nios_system_scene_status
  import nios_system_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               address,
  input  logic                     chipselect,
  input  logic                     read_n,
  input  logic                     write_n,
  input  logic [AVALON_DATA_W-1:0] writedata,
  input  logic [WIDTH-1:0]         in_port,
  output logic [AVALON_DATA_W-1:0] readdata,
  output logic                     irq
);

  logic [WIDTH-1:0] w_s2;
  logic [WIDTH-1:0] r_s3;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_rd_sel;
  logic             w_rd;
  logic             w_wr;
  logic             w_unused;
  scene_reg_e       w_reg;

  nios_system_sync2 #(.WIDTH(WIDTH)) u_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (in_port),
    .o_q     (w_s2)
  );

  assign w_reg    = scene_reg_e'(address);
  assign w_rd     = bus_strobe(chipselect, read_n);
  assign w_wr     = bus_strobe(chipselect, write_n);
  assign w_edge   = w_s2 & ~r_s3;
  assign w_clr    = (w_wr && w_reg == SCENE_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
  assign w_unused = ^writedata;

  always_comb begin
    w_rd_sel = '0;
    case (w_reg)
      SCENE_ADDR_DATA:    w_rd_sel = w_s2;
      SCENE_ADDR_IRQMASK: w_rd_sel = r_irqmask;
      SCENE_ADDR_EDGECAP: w_rd_sel = r_edgecap;
      default:            w_rd_sel = '0;
    endcase
  end

  // A new edge in the same cycle as a clear keeps the bit set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s3      <= '0;
      r_edgecap <= '0;
      r_irqmask <= '0;
      readdata  <= '0;
    end else begin
      r_s3      <= w_s2;
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
      if (w_wr && w_reg == SCENE_ADDR_IRQMASK)
        r_irqmask <= writedata[WIDTH-1:0];
      if (w_rd)
        readdata <= AVALON_DATA_W'(w_rd_sel);
    end
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule
